game_state_controller: RTL and testbench
========================================

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 Parameter NUM_LIVES, default 3: lives granted at game start; legal range 1..15.
REQ-002 Parameter NUM_LEVELS, default 8: number of levels; level index saturates at NUM_LEVELS-1.
REQ-003 Parameter START_DELAY_FRAMES, default 60: frame ticks spent in START_DELAY.
REQ-004 Parameter DEATH_DELAY_FRAMES, default 90: frame ticks spent in DYING.
REQ-005 Parameter NUM_SWITCHES, default 4: width of the debounced switch bus.
REQ-006 Port i_Clk  in  1: the single system clock; all logic is on its rising edge.
REQ-007 Port i_Reset  in  1: synchronous, active-high reset.
REQ-008 Port i_Switch  in  NUM_SWITCHES: debounced switch levels.
REQ-009 Port i_Frame_Tick  in  1: one-cycle pulse per VGA frame.
REQ-010 Port i_Has_Collided  in  1: frog/car collision level.
REQ-011 Port i_Level_Up  in  1: one-cycle pulse when the frog reaches the goal row.
REQ-012 Port i_Pause_Req  in  1: pause toggle pulse; used only under GAME_PAUSE_EN.
REQ-013 Port o_State  out  3: current state encoding.
REQ-014 Port o_Game_Active  out  1: high only in RUNNING.
REQ-015 Port o_Lives  out  4: remaining lives.
REQ-016 Port o_Level  out  $clog2(NUM_LEVELS): current level index.
REQ-017 Port o_Respawn  out  1: one-cycle pulse commanding frog return to base position.
REQ-018 Port o_Game_Over  out  1: high in GAME_OVER.

Function
REQ-019 States: IDLE=0, START_DELAY=1, RUNNING=2, DYING=3, LEVEL_CLEAR=4, GAME_OVER=5, PAUSED=6; any other encoding returns to IDLE on the next cycle.
REQ-020 "Start" is the rising edge of the AND of all i_Switch bits, taken from a registered previous value, so held switches never retrigger.
REQ-021 IDLE or GAME_OVER + start: go to START_DELAY, load lives=NUM_LIVES and level=0, and pulse o_Respawn in the same cycle as the transition.
REQ-022 START_DELAY: the frame counter clears on entry and increments on i_Frame_Tick; exit to RUNNING on the tick that makes count equal START_DELAY_FRAMES. A value of 0 exits on the cycle after entry.
REQ-023 RUNNING + i_Has_Collided: go to DYING and decrement lives by 1 (no underflow below 0).
REQ-024 RUNNING + i_Level_Up without collision: go to LEVEL_CLEAR. If both arrive in the same cycle, collision wins and the level is not advanced.
REQ-025 DYING: the frame counter runs as in REQ-022 against DEATH_DELAY_FRAMES. At expiry, go to GAME_OVER if lives==0; otherwise go to START_DELAY with an o_Respawn pulse.
REQ-026 LEVEL_CLEAR: leave on the next i_Frame_Tick to START_DELAY with an o_Respawn pulse; the level increments, saturating at NUM_LEVELS-1.
REQ-027 i_Has_Collided and i_Level_Up are ignored outside RUNNING.
REQ-028 o_Respawn is never high for more than 1 consecutive cycle.
REQ-029 All outputs are registered; state change is visible 1 cycle after the qualifying input.

Reset
REQ-030 i_Reset high at any clock edge, including mid-delay or in PAUSED, forces: state IDLE, lives 0, level 0, frame counter 0, o_Respawn 0, o_Game_Over 0, o_Game_Active 0, switch-edge register 1.
REQ-031 Forcing the switch-edge register to 1 means switches held through reset do not start a game.

Configuration
REQ-032 Macro GAME_PAUSE_EN defined: an i_Pause_Req pulse in RUNNING goes to PAUSED, and in PAUSED returns to RUNNING. Collision and level-up are ignored while PAUSED; lives, level and frame counter hold.
REQ-033 Macro GAME_PAUSE_EN undefined: i_Pause_Req is ignored, PAUSED is unreachable, and the encoding 6 falls under REQ-019.

Structure
REQ-034 State encodings and default parameter values live in the shared Constants.v.
REQ-035 One sub-module, frame_delay_counter, provides the clear / tick-increment / compare-to-limit frame counter and is instantiated once.

Verification
REQ-036 Reset, then a 0→all-1 switch edge: o_Respawn pulses once, o_Lives=3, o_Level=0; RUNNING follows after 60 ticks.
REQ-037 Collision in RUNNING 3 times: lives go 3→2→1→0, each death spends 90 ticks in DYING, and the third death ends with o_Game_Over=1 and no respawn.
REQ-038 i_Level_Up and i_Has_Collided in the same cycle: state goes to DYING, o_Level is unchanged, o_Lives=2.
REQ-039 Eight level-ups with NUM_LEVELS=8: o_Level reads 7 after the seventh and stays 7 after the eighth.
REQ-040 i_Reset asserted mid-START_DELAY with switches held high: state returns to IDLE, and no start occurs until the switches are released and pressed again.
REQ-041 With GAME_PAUSE_EN: pause in RUNNING, apply collision plus 200 ticks, then unpause: state returns to RUNNING with lives unchanged. Without GAME_PAUSE_EN, the same stimulus leaves the controller in DYING.

Source files
------------

// File: rtl/game_state_controller_pkg.sv
// game_state_controller_pkg
//   Shared definitions for the game state controller: the state encoding,
//   the default parameter values and the frame counter width.
//   Ports: none (package).
package game_state_controller_pkg;

   // Encodings are fixed; they appear on o_State.
   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StStartDelay = 3'd1,
      StRunning    = 3'd2,
      StDying      = 3'd3,
      StLevelClear = 3'd4,
      StGameOver   = 3'd5,
      StPaused     = 3'd6
   } state_e;

   localparam int unsigned DefNumLives         = 3;
   localparam int unsigned DefNumLevels        = 8;
   localparam int unsigned DefStartDelayFrames = 60;
   localparam int unsigned DefDeathDelayFrames = 90;
   localparam int unsigned DefNumSwitches      = 4;

   // Wide enough for any practical frame delay (over 18 minutes at 60 Hz).
   localparam int unsigned FrameCntW = 16;

   // Level index width; a single-level game still needs a 1-bit port.
   function automatic int unsigned level_width(input int unsigned num_levels);
      return (num_levels > 1) ? $clog2(num_levels) : 1;
   endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// game_state_controller_if
//   Groups the game-event inputs and status outputs of the controller.
//   Signals:
//     i_Switch        debounced switch levels
//     i_Frame_Tick    one-cycle pulse per frame
//     i_Has_Collided  frog/car collision level
//     i_Level_Up      one-cycle pulse on reaching the goal row
//     i_Pause_Req     pause toggle pulse (used only when GAME_PAUSE_EN is defined)
//     o_State         current state encoding
//     o_Game_Active   high only while running
//     o_Lives         remaining lives
//     o_Level         current level index
//     o_Respawn       one-cycle frog respawn command
//     o_Game_Over     high in game over
//   Modports: master drives the inputs (game logic / bench), slave is the controller.
interface game_state_controller_if
   import game_state_controller_pkg::*;
#(
   parameter int unsigned NUM_SWITCHES = DefNumSwitches,
   parameter int unsigned NUM_LEVELS   = DefNumLevels
);
   localparam int unsigned LevelW = level_width(NUM_LEVELS);

   logic [NUM_SWITCHES-1:0] i_Switch;
   logic                    i_Frame_Tick;
   logic                    i_Has_Collided;
   logic                    i_Level_Up;
   logic                    i_Pause_Req;
   logic [2:0]              o_State;
   logic                    o_Game_Active;
   logic [3:0]              o_Lives;
   logic [LevelW-1:0]       o_Level;
   logic                    o_Respawn;
   logic                    o_Game_Over;

   modport master (
      output i_Switch, i_Frame_Tick, i_Has_Collided, i_Level_Up, i_Pause_Req,
      input  o_State, o_Game_Active, o_Lives, o_Level, o_Respawn, o_Game_Over
   );

   modport slave (
      input  i_Switch, i_Frame_Tick, i_Has_Collided, i_Level_Up, i_Pause_Req,
      output o_State, o_Game_Active, o_Lives, o_Level, o_Respawn, o_Game_Over
   );

endinterface

// File: rtl/game_state_controller_frame_delay_counter.sv
// frame_delay_counter
//   Counts frame ticks for the timed states. Cleared on entry to a timed
//   state, increments on each tick, and flags expiry combinationally on the
//   tick that brings the count up to the limit (or at once for a zero limit).
//   Ports:
//     clk_i     system clock
//     rst_i     synchronous active-high reset
//     clear_i   zero the count on the next edge
//     tick_i    qualified frame tick (already gated to the timed states)
//     limit_i   number of ticks to spend
//     expire_o  delay complete this cycle
module frame_delay_counter
   import game_state_controller_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 tick_i,
   input  logic [FrameCntW-1:0] limit_i,
   output logic                 expire_o
);

   logic [FrameCntW-1:0] count_q;
   logic [FrameCntW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (tick_i) begin
         count_d = count_q + FrameCntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (limit_i == '0) || (tick_i && ((count_q + FrameCntW'(1)) == limit_i));

endmodule

// File: rtl/game_state_controller.sv
// game_state_controller
//   Top-level game flow FSM: idle -> start delay -> running, with death and
//   level-clear sequences, lives/level bookkeeping and a respawn pulse.
//   Optional pause support is compiled in with the macro GAME_PAUSE_EN.
//   Ports:
//     i_Clk    system clock, all logic on the rising edge
//     i_Reset  synchronous active-high reset
//     bus      game_state_controller_if.slave (switches, frame tick, collision,
//              level-up, pause request in; state, lives, level, respawn and
//              status flags out, all registered)
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int unsigned NUM_LIVES          = DefNumLives,
   parameter int unsigned NUM_LEVELS         = DefNumLevels,
   parameter int unsigned START_DELAY_FRAMES = DefStartDelayFrames,
   parameter int unsigned DEATH_DELAY_FRAMES = DefDeathDelayFrames,
   parameter int unsigned NUM_SWITCHES       = DefNumSwitches
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   game_state_controller_if.slave  bus
);

   localparam int unsigned LevelW = level_width(NUM_LEVELS);
   localparam logic [LevelW-1:0] LevelMax = LevelW'(NUM_LEVELS - 1);

   state_e            state_q, state_d;
   logic [3:0]        lives_q, lives_d;
   logic [LevelW-1:0] level_q, level_d;
   logic              respawn_q, respawn_d;
   logic              game_over_q;
   logic              game_active_q;
   logic              sw_prev_q;

   logic                 sw_all;
   logic                 start;
   logic                 timed_state;
   logic                 cnt_clear;
   logic                 cnt_tick;
   logic [FrameCntW-1:0] cnt_limit;
   logic                 cnt_expire;

   // Start is a rising edge of "all switches on"; the previous value resets to
   // 1 so switches held through reset cannot start a game.
   assign sw_all = &bus.i_Switch;
   assign start  = sw_all & ~sw_prev_q;

   assign timed_state = (state_q == StStartDelay) || (state_q == StDying);
   assign cnt_tick    = bus.i_Frame_Tick && timed_state;
   assign cnt_limit   = (state_q == StDying) ? FrameCntW'(DEATH_DELAY_FRAMES)
                                             : FrameCntW'(START_DELAY_FRAMES);
   // Any state change restarts the count, so each timed state sees it from 0.
   assign cnt_clear   = (state_d != state_q);

   frame_delay_counter u_frame_delay_counter (
      .clk_i    (i_Clk),
      .rst_i    (i_Reset),
      .clear_i  (cnt_clear),
      .tick_i   (cnt_tick),
      .limit_i  (cnt_limit),
      .expire_o (cnt_expire)
   );

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      level_d   = level_q;
      respawn_d = 1'b0;

      case (state_q)
         StIdle, StGameOver: begin
            if (start) begin
               state_d   = StStartDelay;
               lives_d   = 4'(NUM_LIVES);
               level_d   = '0;
               respawn_d = 1'b1;
            end
         end

         StStartDelay: begin
            if (cnt_expire) begin
               state_d = StRunning;
            end
         end

         StRunning: begin
            // Collision outranks a simultaneous level-up.
            if (bus.i_Has_Collided) begin
               state_d = StDying;
               if (lives_q != 4'd0) begin
                  lives_d = lives_q - 4'd1;
               end
            end else if (bus.i_Level_Up) begin
               state_d = StLevelClear;
`ifdef GAME_PAUSE_EN
            end else if (bus.i_Pause_Req) begin
               state_d = StPaused;
`endif
            end
         end

         StDying: begin
            if (cnt_expire) begin
               if (lives_q == 4'd0) begin
                  state_d = StGameOver;
               end else begin
                  state_d   = StStartDelay;
                  respawn_d = 1'b1;
               end
            end
         end

         StLevelClear: begin
            if (bus.i_Frame_Tick) begin
               state_d   = StStartDelay;
               respawn_d = 1'b1;
               if (level_q != LevelMax) begin
                  level_d = level_q + LevelW'(1);
               end
            end
         end

`ifdef GAME_PAUSE_EN
         StPaused: begin
            if (bus.i_Pause_Req) begin
               state_d = StRunning;
            end
         end
`endif

         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifndef GAME_PAUSE_EN
   logic unused_pause_req;
   assign unused_pause_req = bus.i_Pause_Req;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q       <= StIdle;
         lives_q       <= '0;
         level_q       <= '0;
         respawn_q     <= 1'b0;
         game_over_q   <= 1'b0;
         game_active_q <= 1'b0;
         sw_prev_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         level_q       <= level_d;
         respawn_q     <= respawn_d;
         game_over_q   <= (state_d == StGameOver);
         game_active_q <= (state_d == StRunning);
         sw_prev_q     <= sw_all;
      end
   end

   assign bus.o_State       = state_q;
   assign bus.o_Game_Active = game_active_q;
   assign bus.o_Lives       = lives_q;
   assign bus.o_Level       = level_q;
   assign bus.o_Respawn     = respawn_q;
   assign bus.o_Game_Over   = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller
//   Self-checking bench for game_state_controller: directed game scenarios
//   with randomised frame-tick spacing, idle gaps and switch patterns, checked
//   against a game-level model of lives, level and state.
module tb_game_state_controller;

   localparam int unsigned NumLives    = 3;
   localparam int unsigned NumLevels   = 8;
   localparam int unsigned StartFrames = 60;
   localparam int unsigned DeathFrames = 90;
   localparam int unsigned NumSwitches = 4;
   localparam int unsigned PauseTicks  = 200;

   localparam int SIdle = 0, SStart = 1, SRun = 2, SDying = 3;
   localparam int SClear = 4, SOver = 5, SPaused = 6;

   logic clk = 1'b0;
   logic rst;

   game_state_controller_if #(
      .NUM_SWITCHES (NumSwitches),
      .NUM_LEVELS   (NumLevels)
   ) bus ();

   game_state_controller #(
      .NUM_LIVES          (NumLives),
      .NUM_LEVELS         (NumLevels),
      .START_DELAY_FRAMES (StartFrames),
      .DEATH_DELAY_FRAMES (DeathFrames),
      .NUM_SWITCHES       (NumSwitches)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int exp_lives   = 0;
   int exp_level   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(0, 3)) cyc();
   endtask

   task automatic deliver_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         idle_gap();
         bus.i_Frame_Tick = 1'b1;
         cyc();
         bus.i_Frame_Tick = 1'b0;
      end
   endtask

   // Switches: some pattern that is not all-on, then all-on.
   task automatic press_start();
      bus.i_Switch = NumSwitches'($urandom_range(0, (1 << NumSwitches) - 2));
      repeat ($urandom_range(1, 3)) cyc();
      bus.i_Switch = '1;
      cyc();
      exp_lives = NumLives;
      exp_level = 0;
      chk("start_state", bus.o_State, SStart);
      chk("start_respawn", bus.o_Respawn, 1);
      chk("start_lives", bus.o_Lives, exp_lives);
      chk("start_level", bus.o_Level, exp_level);
      chk("start_gameover", bus.o_Game_Over, 0);
      cyc();
      chk("respawn_single", bus.o_Respawn, 0);
   endtask

   task automatic start_to_running();
      deliver_ticks(StartFrames - 1);
      chk("start_hold", bus.o_State, SStart);
      chk("start_inactive", bus.o_Game_Active, 0);
      deliver_ticks(1);
      chk("run_state", bus.o_State, SRun);
      chk("run_active", bus.o_Game_Active, 1);
   endtask

   task automatic die(input bit with_level_up);
      idle_gap();
      bus.i_Has_Collided = 1'b1;
      bus.i_Level_Up     = with_level_up;
      cyc();
      bus.i_Has_Collided = 1'b0;
      bus.i_Level_Up     = 1'b0;
      exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
      chk("die_state", bus.o_State, SDying);
      chk("die_lives", bus.o_Lives, exp_lives);
      chk("die_level", bus.o_Level, exp_level);
      // Game events while dying must be ignored.
      bus.i_Has_Collided = 1'b1;
      bus.i_Level_Up     = 1'b1;
      cyc();
      bus.i_Has_Collided = 1'b0;
      bus.i_Level_Up     = 1'b0;
      chk("dying_ignore_lives", bus.o_Lives, exp_lives);
      chk("dying_ignore_state", bus.o_State, SDying);
      deliver_ticks(DeathFrames - 1);
      chk("dying_hold", bus.o_State, SDying);
      deliver_ticks(1);
      if (exp_lives == 0) begin
         chk("over_state", bus.o_State, SOver);
         chk("over_flag", bus.o_Game_Over, 1);
         chk("over_no_respawn", bus.o_Respawn, 0);
      end else begin
         chk("rebirth_state", bus.o_State, SStart);
         chk("rebirth_respawn", bus.o_Respawn, 1);
         start_to_running();
      end
   endtask

   task automatic level_clear();
      idle_gap();
      bus.i_Level_Up = 1'b1;
      cyc();
      bus.i_Level_Up = 1'b0;
      chk("clear_state", bus.o_State, SClear);
      repeat ($urandom_range(1, 3)) cyc();
      chk("clear_wait", bus.o_State, SClear);
      bus.i_Frame_Tick = 1'b1;
      cyc();
      bus.i_Frame_Tick = 1'b0;
      exp_level = (exp_level + 1 < NumLevels) ? exp_level + 1 : NumLevels - 1;
      chk("clear_next", bus.o_State, SStart);
      chk("clear_respawn", bus.o_Respawn, 1);
      chk("clear_level", bus.o_Level, exp_level);
      chk("clear_lives", bus.o_Lives, exp_lives);
      start_to_running();
   endtask

   task automatic pulse_pause();
      bus.i_Pause_Req = 1'b1;
      cyc();
      bus.i_Pause_Req = 1'b0;
   endtask

   initial begin
      int cycle_len;
      int deaths;
      int rem;

      rst                = 1'b1;
      bus.i_Switch       = NumSwitches'($urandom);
      bus.i_Frame_Tick   = 1'b0;
      bus.i_Has_Collided = 1'b0;
      bus.i_Level_Up     = 1'b0;
      bus.i_Pause_Req    = 1'b0;
      repeat (3) cyc();
      chk("rst_state", bus.o_State, SIdle);
      chk("rst_lives", bus.o_Lives, 0);
      chk("rst_level", bus.o_Level, 0);
      chk("rst_respawn", bus.o_Respawn, 0);
      chk("rst_gameover", bus.o_Game_Over, 0);
      chk("rst_active", bus.o_Game_Active, 0);

      // Switches held on through reset release must not start a game.
      bus.i_Switch = '1;
      cyc();
      rst = 1'b0;
      repeat (4) cyc();
      chk("held_no_start", bus.o_State, SIdle);

      press_start();
      start_to_running();

      // Simultaneous collision and level-up: collision wins.
      die(1'b1);

      for (int k = 1; k <= 8; k++) begin
         level_clear();
         if (k == 7) chk("level_after_7", bus.o_Level, NumLevels - 1);
      end
      chk("level_after_8", bus.o_Level, NumLevels - 1);

      die(1'b0);
      die(1'b0);

      // Switches are still held from the last press: no restart.
      repeat (5) cyc();
      chk("over_held", bus.o_State, SOver);
      press_start();

      // Reset in the middle of the start delay, switches held.
      deliver_ticks($urandom_range(1, StartFrames - 2));
      chk("mid_start", bus.o_State, SStart);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_state", bus.o_State, SIdle);
      chk("midrst_lives", bus.o_Lives, 0);
      repeat ($urandom_range(2, 6)) cyc();
      chk("midrst_held", bus.o_State, SIdle);
      press_start();
      start_to_running();

      // Pause scenario: collision held over PauseTicks frames, then unpause.
      pulse_pause();
`ifdef GAME_PAUSE_EN
      chk("paused_state", bus.o_State, SPaused);
      chk("paused_inactive", bus.o_Game_Active, 0);
`else
      chk("pause_ignored", bus.o_State, SRun);
`endif
      bus.i_Has_Collided = 1'b1;
      deliver_ticks(PauseTicks);
      bus.i_Has_Collided = 1'b0;
      cyc();
      pulse_pause();
`ifdef GAME_PAUSE_EN
      chk("unpause_state", bus.o_State, SRun);
      chk("unpause_lives", bus.o_Lives, exp_lives);
`else
      // Held collision: each lap is a death delay plus a start delay, after
      // which the frog collides again at once.
      cycle_len = DeathFrames + StartFrames;
      deaths    = 1;
      rem       = PauseTicks;
      while (rem >= cycle_len) begin
         rem -= cycle_len;
         deaths++;
      end
      exp_lives = exp_lives - deaths;
      chk("nopause_state", bus.o_State, (rem < DeathFrames) ? SDying : SStart);
      chk("nopause_lives", bus.o_Lives, exp_lives);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
